// File: rtl/alu_con_flags.sv
// N-bit ALU (ADD/SUB/XOR/NOT) with ARM-style NZCV flags.
// Result, flags and the valid pulse are registered for one cycle of latency.
module alu_con_flags #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   ALUControl,
    output logic [N-1:0] Result,
    output logic [3:0]   ALUFlags,
    output logic         valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    logic [N-1:0] b_op;
    logic [N:0]   sum;
    logic [N-1:0] result_next;
    logic         carry_next;
    logic         ovf_next;
    logic [3:0]   flags_next;

    logic [N-1:0] result_reg;
    logic [3:0]   flags_reg;
    logic         valid_reg;

    // One shared adder: SUB reuses it as A + ~B + 1, so C means "no borrow".
    assign b_op = (ALUControl == OP_SUB) ? ~B : B;
    assign sum  = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, (ALUControl == OP_SUB)};

    always_comb begin
        result_next = sum[N-1:0];
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                result_next = sum[N-1:0];
                carry_next  = sum[N];
                ovf_next    = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
            end
            OP_SUB: begin
                result_next = sum[N-1:0];
                carry_next  = sum[N];
                ovf_next    = (A[N-1] != B[N-1]) && (sum[N-1] != A[N-1]);
            end
            OP_XOR: result_next = A ^ B;
            OP_NOT: result_next = ~A;
        endcase
        flags_next = {result_next[N-1], (result_next == '0), carry_next, ovf_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            flags_reg  <= 4'b0000;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= en;
            if (en) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
            end
        end
    end

    assign Result   = result_reg;
    assign ALUFlags = flags_reg;
    assign valid    = valid_reg;

endmodule

// File: tb/tb_alu_con_flags.sv
// Scoreboard bench for alu_con_flags: driver pushes expected results,
// monitor pops on valid and checks hold behaviour while valid is low.
module tb_alu_con_flags;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] A   = '0;
    logic [N-1:0] B   = '0;
    logic [1:0]   ALUControl = 2'b00;
    logic [N-1:0] Result;
    logic [3:0]   ALUFlags;
    logic         valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [N-1:0] res;
        logic [3:0]   flags;
    } exp_t;

    exp_t exp_q[$];

    logic [N-1:0] held_res   = '0;
    logic [3:0]   held_flags = 4'b0000;

    alu_con_flags #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: pop on valid, otherwise outputs must hold the last result.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'b0, valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_result"}, Result, e.res);
                    check({e.name, "_flags"}, {28'b0, ALUFlags}, {28'b0, e.flags});
                    $display("txn %s result=0x%08h flags=%04b", e.name, Result, ALUFlags);
                    held_res   = e.res;
                    held_flags = e.flags;
                end
            end else begin
                check("hold_valid", {31'b0, valid}, 32'd0);
                check("hold_result", Result, held_res);
                check("hold_flags", {28'b0, ALUFlags}, {28'b0, held_flags});
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] r, input logic [3:0] f);
        exp_t e;
        e.name = name; e.res = r; e.flags = f;
        A = a; B = b; ALUControl = op; en = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            en = 1'b0;
            A = $urandom; B = $urandom; ALUControl = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
    endtask

    initial begin
        #12;
        check("reset_result", Result, '0);
        check("reset_flags", {28'b0, ALUFlags}, 32'd0);
        check("reset_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Streaming, en high every cycle
        issue("sub_5_2",    2'b01, 32'd5, 32'd2, 32'h00000003, 4'b0010);
        issue("sub_2_5",    2'b01, 32'd2, 32'd5, 32'hFFFFFFFD, 4'b1000);
        issue("sub_5_5",    2'b01, 32'd5, 32'd5, 32'h00000000, 4'b0110);
        issue("add_38_40",  2'b00, 32'h38, 32'h40, 32'h00000078, 4'b0000);
        issue("add_58_m1c", 2'b00, 32'h58, 32'hFFFFFFE4, 32'h0000003C, 4'b0010);
        issue("add_40_m4",  2'b00, 32'h40, 32'hFFFFFFFC, 32'h0000003C, 4'b0010);
        issue("add_ovf",    2'b00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001);
        issue("add_wrap",   2'b00, 32'hFFFFFFFF, 32'd1, 32'h00000000, 4'b0110);
        issue("sub_ovf",    2'b01, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
        issue("xor_3_e",    2'b10, 32'h3, 32'hE, 32'h0000000D, 4'b0000);
        issue("xor_same",   2'b10, 32'h1234, 32'h1234, 32'h00000000, 4'b0100);
        issue("not_0",      2'b11, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b1000);
        issue("not_ones",   2'b11, 32'hFFFFFFFF, 32'h5, 32'h00000000, 4'b0100);

        // Single pulse then three idle cycles with changing inputs
        issue("pulse_add",  2'b00, 32'h38, 32'h40, 32'h00000078, 4'b0000);
        idle(3);

        // Mid-cycle reset with en high: cleared at once, sampled op discarded
        A = 32'h7FFFFFFF; B = 32'd1; ALUControl = 2'b00; en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_result", Result, '0);
        check("midrst_flags", {28'b0, ALUFlags}, 32'd0);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        @(posedge clk); #1;
        check("rst_edge_result", Result, '0);
        check("rst_edge_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        held_res = '0; held_flags = 4'b0000;
        rst = 1'b0;
        idle(1);
        issue("post_rst_sub", 2'b01, 32'd5, 32'd2, 32'h00000003, 4'b0010);
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
